// File: rtl/riscv_bp_ctrl.sv
// Write-port controller for the correlating branch-prediction table: sweep
// initialisation/flush, 2-bit counter update, global history and drop counting.
module riscv_bp_ctrl #(
    parameter int          XLEN              = 32,
    parameter int          BP_GLOBAL_BITS    = 2,
    parameter int          BP_LOCAL_BITS     = 10,
    parameter int          BP_LOCAL_BITS_LSB = 2,
    parameter logic [1:0]  INIT_PREDICT      = 2'b01,
    parameter int          DROP_CNT_BITS     = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush_req,
    input  logic                                    bu_update,
    input  logic [XLEN-1:0]                         bu_pc,
    input  logic [BP_GLOBAL_BITS-1:0]               bu_history,
    input  logic [1:0]                              bu_predict,
    input  logic                                    bu_btaken,
    output logic [BP_GLOBAL_BITS-1:0]               ghr,
    output logic                                    bp_we,
    output logic [BP_GLOBAL_BITS+BP_LOCAL_BITS-1:0] bp_waddr,
    output logic [1:0]                              bp_wdata,
    output logic                                    bp_valid,
    output logic                                    busy,
    output logic [DROP_CNT_BITS-1:0]                drop_cnt
);

    localparam int ADR_BITS = BP_GLOBAL_BITS + BP_LOCAL_BITS;

    typedef enum logic [0:0] {
        SWEEP = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                     state_r;
    state_t                     state_s;
    logic [ADR_BITS-1:0]        sweep_adr_r;
    logic [ADR_BITS-1:0]        sweep_adr_s;
    logic [BP_GLOBAL_BITS-1:0]  ghr_s;
    logic                       bp_we_s;
    logic [ADR_BITS-1:0]        bp_waddr_s;
    logic [1:0]                 bp_wdata_s;
    logic                       bp_valid_s;
    logic                       busy_s;
    logic [DROP_CNT_BITS-1:0]   drop_cnt_s;
    logic                       drop_s;
    logic                       unused_pc_s;

    // Only a slice of the PC addresses the table.
    assign unused_pc_s = ^bu_pc;

    // Counter order 00 <-> 01 <-> 11 <-> 10, saturating at both ends.
    function automatic logic [1:0] next_counter(input logic [1:0] pred, input logic taken);
        logic [1:0] nxt;
        nxt[0] = pred[1] ^ taken;
        nxt[1] = (pred[1] & ~pred[0]) | (taken & pred[0]);
        return nxt;
    endfunction

    // Next-state, write-port and history decisions.
    always_comb begin
        state_s     = state_r;
        sweep_adr_s = sweep_adr_r;
        ghr_s       = ghr;
        bp_we_s     = 1'b0;
        bp_waddr_s  = bp_waddr;
        bp_wdata_s  = bp_wdata;
        bp_valid_s  = bp_valid;
        busy_s      = busy;
        drop_s      = bu_update & (flush_req | (state_r == SWEEP));

        case (state_r)
            SWEEP: begin
                if (flush_req) begin
                    sweep_adr_s = {ADR_BITS{1'b0}};
                    ghr_s       = {BP_GLOBAL_BITS{1'b0}};
                end else begin
                    bp_we_s     = 1'b1;
                    bp_waddr_s  = sweep_adr_r;
                    bp_wdata_s  = INIT_PREDICT;
                    sweep_adr_s = sweep_adr_r + ADR_BITS'(1);
                    if (sweep_adr_r == {ADR_BITS{1'b1}}) begin
                        state_s    = READY;
                        bp_valid_s = 1'b1;
                        busy_s     = 1'b0;
                    end else begin
                        state_s    = SWEEP;
                    end
                end
            end
            READY: begin
                if (flush_req) begin
                    state_s     = SWEEP;
                    sweep_adr_s = {ADR_BITS{1'b0}};
                    ghr_s       = {BP_GLOBAL_BITS{1'b0}};
                    bp_valid_s  = 1'b0;
                    busy_s      = 1'b1;
                end else if (bu_update) begin
                    bp_we_s    = 1'b1;
                    bp_waddr_s = {bu_history, bu_pc[BP_LOCAL_BITS_LSB +: BP_LOCAL_BITS]};
                    bp_wdata_s = next_counter(bu_predict, bu_btaken);
                    // Truncating the concatenation keeps the newest BP_GLOBAL_BITS outcomes.
                    ghr_s      = BP_GLOBAL_BITS'({ghr, bu_btaken});
                end else begin
                    bp_we_s    = 1'b0;
                end
            end
            default: begin
                state_s     = SWEEP;
                sweep_adr_s = {ADR_BITS{1'b0}};
                bp_valid_s  = 1'b0;
                busy_s      = 1'b1;
            end
        endcase

        if (drop_s && (drop_cnt != {DROP_CNT_BITS{1'b1}})) begin
            drop_cnt_s = drop_cnt + DROP_CNT_BITS'(1);
        end else begin
            drop_cnt_s = drop_cnt;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= SWEEP;
            sweep_adr_r <= {ADR_BITS{1'b0}};
            ghr         <= {BP_GLOBAL_BITS{1'b0}};
            bp_we       <= 1'b0;
            bp_waddr    <= {ADR_BITS{1'b0}};
            bp_wdata    <= 2'b00;
            bp_valid    <= 1'b0;
            busy        <= 1'b1;
            drop_cnt    <= {DROP_CNT_BITS{1'b0}};
        end else begin
            state_r     <= state_s;
            sweep_adr_r <= sweep_adr_s;
            ghr         <= ghr_s;
            bp_we       <= bp_we_s;
            bp_waddr    <= bp_waddr_s;
            bp_wdata    <= bp_wdata_s;
            bp_valid    <= bp_valid_s;
            busy        <= busy_s;
            drop_cnt    <= drop_cnt_s;
        end
    end

endmodule

// File: tb/tb_riscv_bp_ctrl.sv
// Directed bench for riscv_bp_ctrl with a 16-entry table (GLOBAL=2, LOCAL=2).
module tb_riscv_bp_ctrl;

    localparam int XLEN  = 32;
    localparam int GB    = 2;
    localparam int LB    = 2;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush_req = 1'b0;
    logic            bu_update = 1'b0;
    logic [XLEN-1:0] bu_pc = 32'h0;
    logic [GB-1:0]   bu_history = 2'b00;
    logic [1:0]      bu_predict = 2'b00;
    logic            bu_btaken = 1'b0;
    logic [GB-1:0]   ghr;
    logic            bp_we;
    logic [GB+LB-1:0] bp_waddr;
    logic [1:0]      bp_wdata;
    logic            bp_valid;
    logic            busy;
    logic [7:0]      drop_cnt;

    int n_vec = 0;
    int n_mis = 0;

    riscv_bp_ctrl #(
        .XLEN(XLEN), .BP_GLOBAL_BITS(GB), .BP_LOCAL_BITS(LB),
        .BP_LOCAL_BITS_LSB(2), .INIT_PREDICT(2'b01), .DROP_CNT_BITS(8)
    ) dut (
        .clk(clk), .rst(rst), .flush_req(flush_req), .bu_update(bu_update),
        .bu_pc(bu_pc), .bu_history(bu_history), .bu_predict(bu_predict),
        .bu_btaken(bu_btaken), .ghr(ghr), .bp_we(bp_we), .bp_waddr(bp_waddr),
        .bp_wdata(bp_wdata), .bp_valid(bp_valid), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects DEPTH consecutive init writes 0..DEPTH-1, then an idle READY cycle.
    task automatic sweep_expect(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            check_vec({tag, "_we"}, 32'(bp_we), 32'd1);
            check_vec({tag, "_waddr"}, 32'(bp_waddr), 32'(i));
            check_vec({tag, "_wdata"}, 32'(bp_wdata), 32'd1);
            check_vec({tag, "_busy"}, 32'(busy), (i == DEPTH - 1) ? 32'd0 : 32'd1);
            check_vec({tag, "_valid"}, 32'(bp_valid), (i == DEPTH - 1) ? 32'd1 : 32'd0);
        end
        tick();
        check_vec({tag, "_idle_we"}, 32'(bp_we), 32'd0);
    endtask

    // Directed update vectors: pc, history, predict, taken, expected waddr/wdata/ghr.
    logic [31:0] tv_pc    [4] = '{32'h0000_0004, 32'h0000_0008, 32'h0000_03F0, 32'h0000_1234};
    logic [1:0]  tv_hist  [4] = '{2'b01, 2'b00, 2'b11, 2'b11};
    logic [1:0]  tv_pred  [4] = '{2'b10, 2'b00, 2'b11, 2'b11};
    logic        tv_tkn   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0]  tv_waddr [4] = '{4'h5, 4'h2, 4'hC, 4'hD};
    logic [1:0]  tv_wdata [4] = '{2'b10, 2'b00, 2'b01, 2'b10};
    logic [1:0]  tv_ghr   [4] = '{2'b11, 2'b10, 2'b00, 2'b01};

    initial begin
        tick();
        tick();
        check_vec("rst_we", 32'(bp_we), 32'd0);
        check_vec("rst_busy", 32'(busy), 32'd1);
        check_vec("rst_valid", 32'(bp_valid), 32'd0);
        check_vec("rst_ghr", 32'(ghr), 32'd0);
        check_vec("rst_waddr", 32'(bp_waddr), 32'd0);
        check_vec("rst_wdata", 32'(bp_wdata), 32'd0);
        check_vec("rst_drop", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        sweep_expect("init");

        // Basic update: weakly not-taken goes to weakly taken.
        bu_update = 1'b1; bu_pc = 32'h0000_000C; bu_history = 2'b10;
        bu_predict = 2'b01; bu_btaken = 1'b1;
        tick();
        bu_update = 1'b0;
        check_vec("upd_we", 32'(bp_we), 32'd1);
        check_vec("upd_waddr", 32'(bp_waddr), 32'hB);
        check_vec("upd_wdata", 32'(bp_wdata), 32'h3);
        check_vec("upd_ghr", 32'(ghr), 32'h1);
        tick();
        check_vec("hold_we", 32'(bp_we), 32'd0);
        check_vec("hold_waddr", 32'(bp_waddr), 32'hB);
        check_vec("hold_wdata", 32'(bp_wdata), 32'h3);

        for (int v = 0; v < 4; v++) begin
            bu_update = 1'b1; bu_pc = tv_pc[v]; bu_history = tv_hist[v];
            bu_predict = tv_pred[v]; bu_btaken = tv_tkn[v];
            tick();
            check_vec($sformatf("tv%0d_we", v), 32'(bp_we), 32'd1);
            check_vec($sformatf("tv%0d_waddr", v), 32'(bp_waddr), 32'(tv_waddr[v]));
            check_vec($sformatf("tv%0d_wdata", v), 32'(bp_wdata), 32'(tv_wdata[v]));
            check_vec($sformatf("tv%0d_ghr", v), 32'(ghr), 32'(tv_ghr[v]));
        end
        check_vec("ready_drop", 32'(drop_cnt), 32'd0);

        // Flush beats a simultaneous update in READY.
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0; bu_update = 1'b0;
        check_vec("fl_we", 32'(bp_we), 32'd0);
        check_vec("fl_busy", 32'(busy), 32'd1);
        check_vec("fl_valid", 32'(bp_valid), 32'd0);
        check_vec("fl_ghr", 32'(ghr), 32'd0);
        check_vec("fl_drop", 32'(drop_cnt), 32'd1);

        // Sweep writes 0..6, an update dropped at 3, then flush at sweep_adr 7.
        for (int k = 0; k < 7; k++) begin
            bu_update = (k == 3);
            bu_btaken = 1'b1;
            tick();
            check_vec($sformatf("sw%0d_waddr", k), 32'(bp_waddr), 32'(k));
            check_vec($sformatf("sw%0d_we", k), 32'(bp_we), 32'd1);
        end
        bu_update = 1'b0;
        check_vec("swdrop_cnt", 32'(drop_cnt), 32'd2);
        check_vec("swdrop_ghr", 32'(ghr), 32'd0);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        check_vec("swfl_we", 32'(bp_we), 32'd0);
        check_vec("swfl_busy", 32'(busy), 32'd1);
        sweep_expect("reflush");

        // Asynchronous reset mid-sweep.
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check_vec("arst_sw_we", 32'(bp_we), 32'd0);
        check_vec("arst_sw_waddr", 32'(bp_waddr), 32'd0);
        check_vec("arst_sw_busy", 32'(busy), 32'd1);
        check_vec("arst_sw_drop", 32'(drop_cnt), 32'd0);
        tick();
        rst = 1'b0;
        sweep_expect("post_rst1");

        // Asynchronous reset right after an update write.
        bu_update = 1'b1; bu_pc = 32'h0000_000C; bu_history = 2'b11;
        bu_predict = 2'b01; bu_btaken = 1'b1;
        tick();
        bu_update = 1'b0;
        check_vec("pre_arst_we", 32'(bp_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_vec("arst_up_we", 32'(bp_we), 32'd0);
        check_vec("arst_up_ghr", 32'(ghr), 32'd0);
        check_vec("arst_up_valid", 32'(bp_valid), 32'd0);
        check_vec("arst_up_wdata", 32'(bp_wdata), 32'd0);
        tick();
        rst = 1'b0;
        sweep_expect("post_rst2");

        // Drop counter saturation: flush and update together every cycle.
        flush_req = 1'b1; bu_update = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (c == 254) check_vec("drop_254", 32'(drop_cnt), 32'd254);
            if (c == 255) check_vec("drop_255", 32'(drop_cnt), 32'd255);
        end
        check_vec("drop_sat", 32'(drop_cnt), 32'd255);
        check_vec("drop_busy", 32'(busy), 32'd1);
        flush_req = 1'b0; bu_update = 1'b0;
        sweep_expect("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
